vas_mem_port_arbiter: RTL



---
 rtl/vas_mem_port_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vas_mem_port_arbiter.sv
// Shares one DTLB/dCache port between scalar and vector requesters; grant 1 cycle after request, done 1 cycle after response.
// One operation in flight; losing requester holds its request, anti-starvation burst limit, kill and response watchdog.
module vas_mem_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int MAX_S_BURST = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req_i,
  input  logic              s_is_store_i,
  input  logic [ADDR_W-1:0] s_addr_i,
  input  logic              s_kill_i,
  input  logic              v_req_i,
  input  logic              v_is_store_i,
  input  logic [ADDR_W-1:0] v_addr_i,
  input  logic              v_kill_i,
  output logic              s_gnt_o,
  output logic              v_gnt_o,
  output logic              s_done_o,
  output logic              v_done_o,
  output logic              s_err_o,
  output logic              v_err_o,
  output logic              is_load_o,
  output logic              is_store_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              kill_mem_op_o,
  input  logic              ld_resp_valid_i,
  input  logic              st_resp_gnt_i,
  output logic              busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_KILL = 2'd2;

  logic [1:0]        state;
  logic              owner;
  logic              op_store;
  logic [3:0]        burst;
  logic [9:0]        wdog;
  logic [1:0]        kill_cnt;

  logic              v_win;
  logic              s_win;
  logic              win_store;
  logic [ADDR_W-1:0] win_addr;
  logic              own_kill;
  logic              resp_hit;
  logic              timed_out;

  assign v_win     = v_req_i && (!s_req_i || (burst >= 4'(MAX_S_BURST)));
  assign s_win     = s_req_i && !v_win;
  assign win_store = v_win ? v_is_store_i : s_is_store_i;
  assign win_addr  = v_win ? v_addr_i : s_addr_i;
  assign own_kill  = owner ? v_kill_i : s_kill_i;
  assign resp_hit  = op_store ? st_resp_gnt_i : ld_resp_valid_i;
  assign timed_out = (wdog == 10'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      owner         <= 1'b0;
      op_store      <= 1'b0;
      burst         <= 4'd0;
      wdog          <= 10'd0;
      kill_cnt      <= 2'd0;
      addr_o        <= '0;
      s_gnt_o       <= 1'b0;
      v_gnt_o       <= 1'b0;
      s_done_o      <= 1'b0;
      v_done_o      <= 1'b0;
      s_err_o       <= 1'b0;
      v_err_o       <= 1'b0;
      is_load_o     <= 1'b0;
      is_store_o    <= 1'b0;
      kill_mem_op_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      s_gnt_o    <= 1'b0;
      v_gnt_o    <= 1'b0;
      s_done_o   <= 1'b0;
      v_done_o   <= 1'b0;
      s_err_o    <= 1'b0;
      v_err_o    <= 1'b0;
      is_load_o  <= 1'b0;
      is_store_o <= 1'b0;
      // The burst only matters while the vector side is actually waiting.
      if (!v_req_i) burst <= 4'd0;

      case (state)
        ST_IDLE: begin
          if (v_win || s_win) begin
            owner      <= v_win;
            op_store   <= win_store;
            addr_o     <= win_addr;
            s_gnt_o    <= s_win;
            v_gnt_o    <= v_win;
            is_load_o  <= !win_store;
            is_store_o <= win_store;
            wdog       <= 10'd0;
            busy_o     <= 1'b1;
            state      <= ST_WAIT;
            if (v_win) burst <= 4'd0;
            else if (v_req_i && burst != 4'hf) burst <= burst + 4'd1;
          end
        end
        ST_WAIT: begin
          if (own_kill) begin
            kill_mem_op_o <= 1'b1;
            kill_cnt      <= 2'd1;
            state         <= ST_KILL;
          end else if (timed_out) begin
            s_err_o  <= !owner;
            v_err_o  <= owner;
            kill_cnt <= 2'd0;
            state    <= ST_KILL;
          end else if (resp_hit) begin
            s_done_o <= !owner;
            v_done_o <= owner;
            busy_o   <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            wdog <= wdog + 10'd1;
          end
        end
        ST_KILL: begin
          // kill_cnt counts kill cycles already shown; a timeout enters with 0 so err precedes the kill.
          if (kill_cnt == 2'd2) begin
            kill_mem_op_o <= 1'b0;
            busy_o        <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            kill_mem_op_o <= 1'b1;
            kill_cnt      <= kill_cnt + 2'd1;
          end
        end
        default: begin
          kill_mem_op_o <= 1'b0;
          busy_o        <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
